regfile_pipe: RTL and testbench



---
 rtl/regfile_pipe.sv | 115 +++++++++++
 tb/tb_regfile_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_pipe.sv
// rtl/regfile_pipe.sv - register file with two combinational read ports, staged write port and sequential clear
// Optional feature: define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_pipe #(
    parameter int WIDTH       = 16,
    parameter int AW          = 3,
    parameter int RESET_INDEX = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy
);

    localparam int NREG = 2 ** AW;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    logic [AW:0]      r_cnt;
    logic             r_pend_valid;
    logic [AW-1:0]    r_pend_addr;
    logic [WIDTH-1:0] r_pend_data;
    logic [WIDTH-1:0] r_mem [NREG];

    logic             w_accept;
    logic             w_commit;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [WIDTH-1:0] w_raw_a;
    logic [WIDTH-1:0] w_raw_b;

    function automatic logic [WIDTH-1:0] reset_val(input int idx);
`ifdef REGFILE_R0_ZERO_EN
        if (idx == 0) return '0;
`endif
        return (RESET_INDEX != 0) ? WIDTH'(idx) : '0;
    endfunction

    assign wr_ready = (r_state == S_IDLE) && !clr_req;
    assign busy     = (r_state == S_CLEAR);
    assign w_accept = wr_valid && wr_ready;

`ifdef REGFILE_R0_ZERO_EN
    assign w_commit = r_pend_valid && (r_pend_addr != '0);
`else
    assign w_commit = r_pend_valid;
`endif

    // Staged write is bypassed to the read ports until it lands in the array.
    assign w_hit_a = r_pend_valid && (r_pend_addr == rd_addr_a);
    assign w_hit_b = r_pend_valid && (r_pend_addr == rd_addr_b);
    assign w_raw_a = w_hit_a ? r_pend_data : r_mem[rd_addr_a];
    assign w_raw_b = w_hit_b ? r_pend_data : r_mem[rd_addr_b];

`ifdef REGFILE_R0_ZERO_EN
    assign rd_data_a = (rd_addr_a == '0) ? '0 : w_raw_a;
    assign rd_data_b = (rd_addr_b == '0) ? '0 : w_raw_b;
`else
    assign rd_data_a = w_raw_a;
    assign rd_data_b = w_raw_b;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= reset_val(i);
            end
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else begin
            if (w_commit) begin
                r_mem[r_pend_addr] <= r_pend_data;
            end
            r_pend_valid <= w_accept;
            if (w_accept) begin
                r_pend_addr <= wr_addr;
                r_pend_data <= wr_data;
            end
            // Nothing is pending while clearing, so the clear write never collides with a commit.
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_mem[r_cnt[AW-1:0]] <= '0;
                    if (r_cnt == (AW+1)'(NREG - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_pipe.sv
// tb/tb_regfile_pipe.sv - self-checking bench for regfile_pipe
module tb_regfile_pipe;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        clr_req;
    logic        busy;

    regfile_pipe #(.WIDTH(16), .AW(3), .RESET_INDEX(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wv;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] ea;
        logic [15:0] eb;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];
    exp_t e;
    int n_checks = 0;
    int n_fail   = 0;
    int busy_cycles;
    logic [15:0] r0_exp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] reset_exp(input int i);
        if (R0Z && i == 0) return 16'h0;
        return 16'(i);
    endfunction

    initial begin
        clock = 0; reset = 1;
        rd_addr_a = 0; rd_addr_b = 0;
        wr_valid = 0; wr_addr = 0; wr_data = 0; clr_req = 0;
        r0_exp = R0Z ? 16'h0000 : 16'h1234;

        vecs[0] = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd4, 16'hBEEF, 16'h0004};
        vecs[2] = '{1'b1, 3'd2, 16'h1111, 3'd5, 3'd2, 16'hBEEF, 16'h1111};
        vecs[3] = '{1'b1, 3'd2, 16'h2222, 3'd2, 3'd2, 16'h2222, 16'h2222};
        vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd7, 16'h2222, 16'h0007};
        vecs[5] = '{1'b1, 3'd7, 16'h0F0F, 3'd7, 3'd6, 16'h0F0F, 16'h0006};
        vecs[6] = '{1'b1, 3'd6, 16'hCAFE, 3'd7, 3'd6, 16'h0F0F, 16'hCAFE};
        vecs[7] = '{1'b1, 3'd0, 16'h1234, 3'd0, 3'd1, r0_exp,   16'h0001};
        vecs[8] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, r0_exp,   16'h0003};

        // Reset state
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            #1;
            check($sformatf("reset_rd_a[%0d]", i), 32'(rd_data_a), 32'(reset_exp(i)));
        end
        @(posedge clock); #1;
        reset = 0;

        // Write/bypass/commit vectors
        for (int k = 0; k < 9; k++) begin
            wr_valid  = vecs[k].wv;
            wr_addr   = vecs[k].wa;
            wr_data   = vecs[k].wd;
            rd_addr_a = vecs[k].ra;
            rd_addr_b = vecs[k].rb;
            sb.push_back('{k, vecs[k].ea, vecs[k].eb});
            @(posedge clock); #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("vec%0d_rd_a", e.idx), 32'(rd_data_a), 32'(e.ea));
                check($sformatf("vec%0d_rd_b", e.idx), 32'(rd_data_b), 32'(e.eb));
            end
        end
        wr_valid = 0;

        // Clear with a write held against it
        clr_req = 1;
        #1;
        check("clr_req_blocks_ready", 32'(wr_ready), 32'd0);
        @(posedge clock); #1;
        clr_req  = 0;
        wr_valid = 1; wr_addr = 3'd3; wr_data = 16'hAAAA;
        busy_cycles = 0;
        for (int c = 0; c < 20 && busy; c++) begin
            busy_cycles++;
            if (wr_ready !== 1'b0) check("clear_wr_ready", 32'(wr_ready), 32'd0);
            @(posedge clock); #1;
        end
        wr_valid = 0;
        check("clear_busy_cycles", 32'(busy_cycles), 32'd8);
        check("clear_done_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            check($sformatf("cleared_rd_a[%0d]", i), 32'(rd_data_a), 32'd0);
            check($sformatf("cleared_rd_b[%0d]", 7 - i), 32'(rd_data_b), 32'd0);
        end

        // Reset in the 4th clear cycle
        @(posedge clock); #1;
        clr_req = 1;
        @(posedge clock); #1;
        clr_req = 0;
        repeat (3) @(posedge clock);
        #2;
        check("midclear_busy_before", 32'(busy), 32'd1);
        reset = 1;
        #1;
        check("midclear_busy", 32'(busy), 32'd0);
        check("midclear_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd_addr_b = 3'(i);
            #1;
            check($sformatf("midclear_rd_b[%0d]", i), 32'(rd_data_b), 32'(reset_exp(i)));
        end
        @(posedge clock); #1;
        reset = 0;
        @(posedge clock); #1;
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
